imac_d4: RTL and testbench



---
 rtl/dwt_pkg.sv | 44 ++++
 rtl/idwt_pair_mac.sv | 88 ++++++++
 rtl/imac_d4.sv | 120 ++++++++++++
 tb/tb_imac_d4.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/dwt_pkg.sv
// Shared constants, types and helpers for the inverse D4 pair MAC.
// Holds the Q1.20 synthesis coefficients (with the forward 0.625 scale undone),
// the FSM state encoding, the packed {a, d} pair type, a widening multiply and
// the round/clamp to 8-bit pixels.
package dwt_pkg;

  localparam int COEFF_W    = 22;
  localparam int COEFF_FRAC = 20;
  localparam int ACC_W      = 32;

  localparam logic [COEFF_W-1:0] G0 = 22'd810277;
  localparam logic [COEFF_W-1:0] G1 = 22'd1403447;
  localparam logic [COEFF_W-1:0] G2 = 22'd376051;
  localparam logic [COEFF_W-1:0] G3 = 22'd217113;

  typedef enum logic [1:0] {FIRST, RUN, WRAP} state_e;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } pair_t;

  // Unsigned coefficient times unsigned sample; always fits in ACC_W-1 bits.
  function automatic logic signed [ACC_W-1:0] cmul(input logic [COEFF_W-1:0] g,
                                                   input logic [7:0]         x);
    logic [ACC_W-1:0] p;
    p = ACC_W'(g) * ACC_W'(x);
    return $signed(p);
  endfunction

  // Round half up from Q.20, then saturate to the 8-bit pixel range.
  function automatic logic [7:0] round_clamp(input logic signed [ACC_W-1:0] sum);
    logic signed [ACC_W-1:0] y;
    y = (sum + $signed(ACC_W'(1) << (COEFF_FRAC - 1))) >>> COEFF_FRAC;
    if (y < 0) begin
      return 8'd0;
    end else if (y > 255) begin
      return 8'd255;
    end else begin
      return 8'(y);
    end
  endfunction

endpackage

// File: rtl/idwt_pair_mac.sv
// Three-stage multiply / sum / round-clamp pipeline for one inverse D4 output pair.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   issue_valid_i       compute request this cycle
//   prev_i, cur_i       previous and current {a, d} coefficient pairs
//   issue_row_i/ptr_i   pointers travelling alongside the data
//   pixel_o             {x_even, x_odd}, held between outputs
//   valid_o             one-cycle pulse, three cycles after issue
//   row_o, ptr_o        pointers of the output on pixel_o
module idwt_pair_mac
  import dwt_pkg::*;
#(
  parameter int unsigned PtrW = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            issue_valid_i,
  input  pair_t           prev_i,
  input  pair_t           cur_i,
  input  logic [PtrW-1:0] issue_row_i,
  input  logic [PtrW-1:0] issue_ptr_i,
  output logic [15:0]     pixel_o,
  output logic            valid_o,
  output logic [PtrW-1:0] row_o,
  output logic [PtrW-1:0] ptr_o
);

  logic signed [ACC_W-1:0] prod_d [8];
  logic signed [ACC_W-1:0] prod_q [8];
  logic signed [ACC_W-1:0] sum_even_d, sum_odd_d, sum_even_q, sum_odd_q;
  logic                    v1_q, v2_q, v3_q;
  logic [PtrW-1:0]         row1_q, row2_q, row3_q, ptr1_q, ptr2_q, ptr3_q;
  logic [15:0]             pixel_q;

  // Slots 0..3 feed x_even, 4..7 feed x_odd (all magnitudes, signs applied in the sum).
  always_comb begin
    prod_d[0]  = cmul(G2, prev_i.a);
    prod_d[1]  = cmul(G1, prev_i.d);
    prod_d[2]  = cmul(G0, cur_i.a);
    prod_d[3]  = cmul(G3, cur_i.d);
    prod_d[4]  = cmul(G3, prev_i.a);
    prod_d[5]  = cmul(G0, prev_i.d);
    prod_d[6]  = cmul(G1, cur_i.a);
    prod_d[7]  = cmul(G2, cur_i.d);
    sum_even_d = prod_q[0] + prod_q[1] + prod_q[2] - prod_q[3];
    sum_odd_d  = prod_q[6] - prod_q[4] - prod_q[5] - prod_q[7];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 8; i++) prod_q[i] <= '0;
      sum_even_q <= '0;
      sum_odd_q  <= '0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      v3_q       <= 1'b0;
      row1_q     <= '0;
      row2_q     <= '0;
      row3_q     <= '0;
      ptr1_q     <= '0;
      ptr2_q     <= '0;
      ptr3_q     <= '0;
      pixel_q    <= '0;
    end else begin
      for (int i = 0; i < 8; i++) prod_q[i] <= prod_d[i];
      sum_even_q <= sum_even_d;
      sum_odd_q  <= sum_odd_d;
      v1_q       <= issue_valid_i;
      v2_q       <= v1_q;
      v3_q       <= v2_q;
      row1_q     <= issue_row_i;
      row2_q     <= row1_q;
      ptr1_q     <= issue_ptr_i;
      ptr2_q     <= ptr1_q;
      if (v2_q) begin
        pixel_q <= {round_clamp(sum_even_q), round_clamp(sum_odd_q)};
        row3_q  <= row2_q;
        ptr3_q  <= ptr2_q;
      end
    end
  end

  assign pixel_o = pixel_q;
  assign valid_o = v3_q;
  assign row_o   = row3_q;
  assign ptr_o   = ptr3_q;

endmodule

// File: rtl/imac_d4.sv
// Inverse Daubechies-4 pair MAC: rebuilds {x[2m], x[2m+1]} pixel pairs from a line
// of {a, d} coefficient pairs with periodic extension. The first pair is kept so the
// wrap-around output (pointer 0) can be issued in a one-cycle bubble after the last.
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   coeff_input                     [15:8] a, [7:0] d
//   i_valid / i_ready               input handshake
//   last_coeff                      final pair of the line
//   i_row_column_pointer            line index
//   i_pixel_pointer                 pair index m
//   pixel_output                    [15:8] x[2m], [7:0] x[2m+1]
//   o_valid                         one-cycle pulse per output pair
//   o_row_column_pointer, o_pixel_pointer  pointers of the output
module imac_d4
  import dwt_pkg::*;
#(
  parameter int unsigned HEIGHT = 256,
  parameter int unsigned WIDTH  = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [15:0]                coeff_input,
  input  logic                       i_valid,
  output logic                       i_ready,
  input  logic                       last_coeff,
  input  logic [$clog2(WIDTH)-1:0]   i_row_column_pointer,
  input  logic [$clog2(WIDTH)-1:0]   i_pixel_pointer,
  output logic [15:0]                pixel_output,
  output logic                       o_valid,
  output logic [$clog2(WIDTH)-1:0]   o_row_column_pointer,
  output logic [$clog2(WIDTH)-1:0]   o_pixel_pointer
);

  localparam int unsigned PtrW = $clog2(WIDTH);

  if (WIDTH < 2 || (WIDTH % 2) != 0 || HEIGHT < 1) begin : g_param_check
    $error("imac_d4: WIDTH must be even and >= 2, HEIGHT >= 1");
  end

  state_e          state_q, state_d;
  pair_t           first_q, first_d, prev_q, prev_d, in_pair;
  logic [PtrW-1:0] row_q, row_d;
  logic            transfer;
  logic            issue_valid;
  pair_t           issue_prev, issue_cur;
  logic [PtrW-1:0] issue_row, issue_ptr;

  assign in_pair  = pair_t'(coeff_input);
  assign i_ready  = (state_q != WRAP);
  assign transfer = i_valid && i_ready;

  always_comb begin
    state_d     = state_q;
    first_d     = first_q;
    prev_d      = prev_q;
    row_d       = row_q;
    issue_valid = 1'b0;
    issue_prev  = prev_q;
    issue_cur   = in_pair;
    issue_row   = i_row_column_pointer;
    issue_ptr   = i_pixel_pointer;
    unique case (state_q)
      FIRST: begin
        if (transfer) begin
          first_d = in_pair;
          prev_d  = in_pair;
          row_d   = i_row_column_pointer;
          state_d = last_coeff ? WRAP : RUN;
        end
      end
      RUN: begin
        if (transfer) begin
          issue_valid = 1'b1;
          prev_d      = in_pair;
          if (last_coeff) state_d = WRAP;
        end
      end
      WRAP: begin
        // Close the ring: last pair against the stored first pair.
        issue_valid = 1'b1;
        issue_cur   = first_q;
        issue_row   = row_q;
        issue_ptr   = '0;
        state_d     = FIRST;
      end
      default: state_d = FIRST;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FIRST;
      first_q <= '0;
      prev_q  <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      prev_q  <= prev_d;
      row_q   <= row_d;
    end
  end

  idwt_pair_mac #(
    .PtrW (PtrW)
  ) u_mac (
    .clk_i         (clk),
    .rst_i         (rst),
    .issue_valid_i (issue_valid),
    .prev_i        (issue_prev),
    .cur_i         (issue_cur),
    .issue_row_i   (issue_row),
    .issue_ptr_i   (issue_ptr),
    .pixel_o       (pixel_output),
    .valid_o       (o_valid),
    .row_o         (o_row_column_pointer),
    .ptr_o         (o_pixel_pointer)
  );

endmodule

// File: tb/tb_imac_d4.sv
module tb_imac_d4;

  localparam int unsigned W  = 8;
  localparam int unsigned PW = 3;
  localparam int          NV = 13;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   coeff_input = '0;
  logic          i_valid = 1'b0;
  logic          i_ready;
  logic          last_coeff = 1'b0;
  logic [PW-1:0] i_row_column_pointer = '0;
  logic [PW-1:0] i_pixel_pointer = '0;
  logic [15:0]   pixel_output;
  logic          o_valid;
  logic [PW-1:0] o_row_column_pointer;
  logic [PW-1:0] o_pixel_pointer;

  imac_d4 #(
    .HEIGHT (8),
    .WIDTH  (W)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .coeff_input          (coeff_input),
    .i_valid              (i_valid),
    .i_ready              (i_ready),
    .last_coeff           (last_coeff),
    .i_row_column_pointer (i_row_column_pointer),
    .i_pixel_pointer      (i_pixel_pointer),
    .pixel_output         (pixel_output),
    .o_valid              (o_valid),
    .o_row_column_pointer (o_row_column_pointer),
    .o_pixel_pointer      (o_pixel_pointer)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Each input record also carries the expected value of the output that has the
  // same position within its line (outputs come out as pointers 1..n-1, then 0).
  typedef struct {
    logic [7:0]    a;
    logic [7:0]    d;
    logic          last;
    logic [PW-1:0] row;
    logic [PW-1:0] ptr;
    logic [7:0]    exp_e;
    logic [7:0]    exp_o;
    logic [PW-1:0] exp_ptr;
  } vec_t;

  typedef struct {
    int            cyc;
    logic [PW-1:0] row;
    logic [PW-1:0] ptr;
    logic [15:0]   pix;
  } out_t;

  vec_t vecs [NV];
  int   tcs  [NV];
  out_t qout [$];
  int   total  = 0;
  int   passes = 0;

  always @(negedge clk) begin
    if (!rst && o_valid) qout.push_back('{cyc, o_row_column_pointer, o_pixel_pointer, pixel_output});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Present one pair from the falling edge, hold it until accepted.
  task automatic send(input logic [7:0] a, input logic [7:0] d, input logic last,
                      input logic [PW-1:0] row, input logic [PW-1:0] ptr, output int tc);
    int guard;
    @(negedge clk);
    coeff_input          = {a, d};
    i_valid              = 1'b1;
    last_coeff           = last;
    i_row_column_pointer = row;
    i_pixel_pointer      = ptr;
    guard                = 0;
    while (!i_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check("ready_wait", i_ready, 1);
    tc = cyc;
    @(posedge clk);
    #1;
    if (last) check("ready_low_in_wrap", i_ready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int tc_dummy;
    int n_before;
    int issue;

    // line A row 1: flat 113 -> 128/128 everywhere
    vecs[0]  = '{8'd113, 8'd0, 1'b0, 3'd1, 3'd0, 8'd128, 8'd128, 3'd1};
    vecs[1]  = '{8'd113, 8'd0, 1'b0, 3'd1, 3'd1, 8'd128, 8'd128, 3'd2};
    vecs[2]  = '{8'd113, 8'd0, 1'b0, 3'd1, 3'd2, 8'd128, 8'd128, 3'd3};
    vecs[3]  = '{8'd113, 8'd0, 1'b1, 3'd1, 3'd3, 8'd128, 8'd128, 3'd0};
    // line B row 2: impulse in pair 0
    vecs[4]  = '{8'd100, 8'd0, 1'b0, 3'd2, 3'd0, 8'd36,  8'd0,   3'd1};
    vecs[5]  = '{8'd0,   8'd0, 1'b0, 3'd2, 3'd1, 8'd0,   8'd0,   3'd2};
    vecs[6]  = '{8'd0,   8'd0, 1'b0, 3'd2, 3'd2, 8'd0,   8'd0,   3'd3};
    vecs[7]  = '{8'd0,   8'd0, 1'b1, 3'd2, 3'd3, 8'd77,  8'd134, 3'd0};
    // line C row 3: saturation
    vecs[8]  = '{8'd255, 8'd255, 1'b0, 3'd3, 3'd0, 8'd255, 8'd0, 3'd1};
    vecs[9]  = '{8'd255, 8'd255, 1'b0, 3'd3, 3'd1, 8'd255, 8'd0, 3'd2};
    vecs[10] = '{8'd255, 8'd255, 1'b0, 3'd3, 3'd2, 8'd255, 8'd0, 3'd3};
    vecs[11] = '{8'd255, 8'd255, 1'b1, 3'd3, 3'd3, 8'd255, 8'd0, 3'd0};
    // line D row 4: single pair
    vecs[12] = '{8'd100, 8'd0, 1'b1, 3'd4, 3'd0, 8'd113, 8'd113, 3'd0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_o_valid", o_valid, 0);
    check("rst_pixel", pixel_output, 0);
    check("rst_o_ptr", o_pixel_pointer, 0);
    check("rst_o_row", o_row_column_pointer, 0);
    rst = 1'b0;
    #1;
    check("rst_i_ready", i_ready, 1);

    // Mid-line asynchronous reset with outputs in flight
    send(8'd113, 8'd0, 1'b0, 3'd5, 3'd0, tc_dummy);
    send(8'd113, 8'd0, 1'b0, 3'd5, 3'd1, tc_dummy);
    send(8'd113, 8'd0, 1'b0, 3'd5, 3'd2, tc_dummy);
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    #1;
    check("pre_rst_valid", o_valid, 1);
    check("pre_rst_pixel", pixel_output, 16'h8080);
    check("pre_rst_ptr", o_pixel_pointer, 1);
    check("pre_rst_row", o_row_column_pointer, 5);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_valid", o_valid, 0);
    check("async_rst_pixel", pixel_output, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", i_ready, 1);
    repeat (5) @(negedge clk);
    #1;
    check("flush_count", qout.size(), 1);
    qout.delete();

    // Table stream: lines back to back, next pair held through each WRAP
    for (int r = 0; r < NV; r++) begin
      send(vecs[r].a, vecs[r].d, vecs[r].last, vecs[r].row, vecs[r].ptr, tcs[r]);
    end
    @(negedge clk);
    i_valid    = 1'b0;
    last_coeff = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    check("out_count", qout.size(), NV);
    for (int r = 0; r < NV && r < qout.size(); r++) begin
      issue = vecs[r].last ? tcs[r] + 1 : tcs[r + 1];
      check($sformatf("pix[%0d]", r), qout[r].pix, {vecs[r].exp_e, vecs[r].exp_o});
      check($sformatf("ptr[%0d]", r), qout[r].ptr, vecs[r].exp_ptr);
      check($sformatf("row[%0d]", r), qout[r].row, vecs[r].row);
      check($sformatf("lat[%0d]", r), qout[r].cyc, issue + 3);
    end

    // last_coeff without i_valid must not start a wrap
    n_before   = qout.size();
    last_coeff = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("idle_last_ready", i_ready, 1);
    last_coeff = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("idle_last_no_out", qout.size(), n_before);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
